// File: rtl/mem_sched_pkg.sv
// Shared types for the memory request scheduler: FSM states, requester ids,
// line-offset width and the line-address type used for prefetch merge.
package mem_sched_pkg;

    localparam int MEM_ADDR_W    = 32;
    localparam int MEM_LINE_W    = 256;
    localparam int LINE_OFFSET_W = 5;

    typedef enum logic [1:0] {
        IDLE,
        GNT_INST,
        GNT_DATA,
        GNT_PREF
    } sched_state_e;

    typedef enum logic [1:0] {
        REQ_NONE,
        REQ_INST,
        REQ_DATA,
        REQ_PREF
    } req_id_e;

    // Address with the line offset stripped; two addresses hit the same line
    // exactly when their line_addr_t values are equal.
    typedef logic [MEM_ADDR_W-LINE_OFFSET_W-1:0] line_addr_t;

endpackage

// File: rtl/mem_req_scheduler_if.sv
// Bundle of requester-side and adaptor-side signals of the scheduler.
// slave: the scheduler's view. master: the environment (caches, prefetcher,
// cacheline adaptor) driving requests and memory responses.
interface mem_req_scheduler_if #(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
);
    logic              inst_read;
    logic [ADDR_W-1:0] inst_addr;
    logic [LINE_W-1:0] inst_rdata;
    logic              inst_resp;

    logic              data_read;
    logic              data_write;
    logic [ADDR_W-1:0] data_addr;
    logic [LINE_W-1:0] data_wdata;
    logic [LINE_W-1:0] data_rdata;
    logic              data_resp;

    logic              pref_read;
    logic [ADDR_W-1:0] pref_addr;
    logic [LINE_W-1:0] pref_rdata;
    logic              pref_resp;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_address;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_resp;

    logic [31:0]       perf_inst_cnt;
    logic [31:0]       perf_data_cnt;
    logic [31:0]       perf_pref_cnt;
    logic [31:0]       perf_merge_cnt;

    modport slave (
        input  inst_read, inst_addr, data_read, data_write, data_addr, data_wdata,
               pref_read, pref_addr, mem_rdata, mem_resp,
        output inst_rdata, inst_resp, data_rdata, data_resp, pref_rdata, pref_resp,
               mem_read, mem_write, mem_address, mem_wdata,
               perf_inst_cnt, perf_data_cnt, perf_pref_cnt, perf_merge_cnt
    );

    modport master (
        output inst_read, inst_addr, data_read, data_write, data_addr, data_wdata,
               pref_read, pref_addr, mem_rdata, mem_resp,
        input  inst_rdata, inst_resp, data_rdata, data_resp, pref_rdata, pref_resp,
               mem_read, mem_write, mem_address, mem_wdata,
               perf_inst_cnt, perf_data_cnt, perf_pref_cnt, perf_merge_cnt
    );

endinterface

// File: rtl/sched_age_ctr.sv
// Saturating 4-bit starvation age for one demand requester. Counts losses,
// saturates at LIMIT (promoted), clear wins over increment.
module sched_age_ctr #(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic promoted
);
    logic [3:0] age_q, age_d;

    // Next age: clear on own grant, otherwise count a loss up to LIMIT
    always_comb begin
        age_d = age_q;
        if (clr)
            age_d = '0;
        else if (inc && (age_q < 4'(LIMIT)))
            age_d = age_q + 4'd1;
    end

    // Age register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) age_q <= '0;
        else      age_q <= age_d;
    end

    assign promoted = (age_q >= 4'(LIMIT));

endmodule

// File: rtl/mem_req_scheduler.sv
// Three-requester scheduler (I-cache, D-cache, next-line prefetcher) in front
// of a single line-wide memory port. Priority: promoted demand > data > inst >
// pref, with starvation aging between the two demand requesters and merging of
// an I-cache miss into an in-flight prefetch of the same line.
// Optional: MEM_SCHED_PERF_EN adds four 32-bit completion counters.
module mem_req_scheduler
    import mem_sched_pkg::*;
#(
    parameter int LINE_W       = MEM_LINE_W,
    parameter int ADDR_W       = MEM_ADDR_W,
    parameter int STARVE_LIMIT = 4
) (
    input  logic               clk,
    input  logic               rst,
    mem_req_scheduler_if.slave bus
);
    sched_state_e state_q, state_d;
    req_id_e      pick;
    logic         data_req, merge;
    logic         inst_inc, inst_clr, inst_prom;
    logic         data_inc, data_clr, data_prom;
    line_addr_t   inst_line, pref_line;

    assign data_req  = bus.data_read | bus.data_write;
    assign inst_line = bus.inst_addr[ADDR_W-1:LINE_OFFSET_W];
    assign pref_line = bus.pref_addr[ADDR_W-1:LINE_OFFSET_W];
    assign merge     = (state_q == GNT_PREF) && bus.mem_resp && bus.inst_read &&
                       (inst_line == pref_line);

    sched_age_ctr #(.LIMIT(STARVE_LIMIT)) u_inst_age (
        .clk(clk), .rst(rst), .inc(inst_inc), .clr(inst_clr), .promoted(inst_prom)
    );
    sched_age_ctr #(.LIMIT(STARVE_LIMIT)) u_data_age (
        .clk(clk), .rst(rst), .inc(data_inc), .clr(data_clr), .promoted(data_prom)
    );

    // Arbitration among the currently pending requests
    always_comb begin
        pick = REQ_NONE;
        if (data_prom && data_req)      pick = REQ_DATA;
        else if (inst_prom && bus.inst_read) pick = REQ_INST;
        else if (data_req)              pick = REQ_DATA;
        else if (bus.inst_read)         pick = REQ_INST;
        else if (bus.pref_read)         pick = REQ_PREF;
    end

    // Next state, memory-side drive, completion pulses and age updates
    always_comb begin
        state_d         = state_q;
        bus.mem_read    = 1'b0;
        bus.mem_write   = 1'b0;
        bus.mem_address = '0;
        bus.mem_wdata   = '0;
        bus.inst_resp   = 1'b0;
        bus.data_resp   = 1'b0;
        bus.pref_resp   = 1'b0;
        inst_inc        = 1'b0;
        inst_clr        = 1'b0;
        data_inc        = 1'b0;
        data_clr        = 1'b0;
        case (state_q)
            IDLE: begin
                case (pick)
                    REQ_DATA: begin
                        state_d  = GNT_DATA;
                        data_clr = 1'b1;
                        inst_inc = bus.inst_read;
                    end
                    REQ_INST: begin
                        state_d  = GNT_INST;
                        inst_clr = 1'b1;
                        data_inc = data_req;
                    end
                    REQ_PREF: state_d = GNT_PREF;
                    default:  state_d = IDLE;
                endcase
            end
            GNT_INST: begin
                bus.mem_read    = bus.inst_read;
                bus.mem_address = {inst_line, LINE_OFFSET_W'(0)};
                if (bus.mem_resp) begin
                    bus.inst_resp = 1'b1;
                    state_d       = IDLE;
                end
            end
            GNT_DATA: begin
                bus.mem_read    = bus.data_read;
                bus.mem_write   = bus.data_write;
                bus.mem_address = {bus.data_addr[ADDR_W-1:LINE_OFFSET_W], LINE_OFFSET_W'(0)};
                bus.mem_wdata   = bus.data_wdata;
                if (bus.mem_resp) begin
                    bus.data_resp = 1'b1;
                    state_d       = IDLE;
                end
            end
            GNT_PREF: begin
                bus.mem_read    = bus.pref_read;
                bus.mem_address = {pref_line, LINE_OFFSET_W'(0)};
                if (bus.mem_resp) begin
                    bus.pref_resp = 1'b1;
                    state_d       = IDLE;
                    // Same-line demand miss rides along on the prefetch fill
                    if (merge) begin
                        bus.inst_resp = 1'b1;
                        inst_clr      = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; async reset drops any in-flight memory command at once
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    assign bus.inst_rdata = bus.inst_resp ? bus.mem_rdata : '0;
    assign bus.data_rdata = bus.data_resp ? bus.mem_rdata : '0;
    assign bus.pref_rdata = bus.pref_resp ? bus.mem_rdata : '0;

`ifdef MEM_SCHED_PERF_EN
    logic [31:0] perf_inst_q, perf_inst_d, perf_data_q, perf_data_d;
    logic [31:0] perf_pref_q, perf_pref_d, perf_merge_q, perf_merge_d;

    // Completion counters, wrapping; a merge counts as inst, pref and merge
    always_comb begin
        perf_inst_d  = perf_inst_q  + 32'(bus.inst_resp);
        perf_data_d  = perf_data_q  + 32'(bus.data_resp);
        perf_pref_d  = perf_pref_q  + 32'(bus.pref_resp);
        perf_merge_d = perf_merge_q + 32'(merge);
    end

    // Counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_inst_q  <= '0;
            perf_data_q  <= '0;
            perf_pref_q  <= '0;
            perf_merge_q <= '0;
        end else begin
            perf_inst_q  <= perf_inst_d;
            perf_data_q  <= perf_data_d;
            perf_pref_q  <= perf_pref_d;
            perf_merge_q <= perf_merge_d;
        end
    end

    assign bus.perf_inst_cnt  = perf_inst_q;
    assign bus.perf_data_cnt  = perf_data_q;
    assign bus.perf_pref_cnt  = perf_pref_q;
    assign bus.perf_merge_cnt = perf_merge_q;
`else
    assign bus.perf_inst_cnt  = '0;
    assign bus.perf_data_cnt  = '0;
    assign bus.perf_pref_cnt  = '0;
    assign bus.perf_merge_cnt = '0;
`endif

    // A granted requester must hold its request until the completion pulse
    a_inst_held: assert property (@(posedge clk) disable iff (!rst)
        (state_q == GNT_INST) |-> bus.inst_read);
    a_data_held: assert property (@(posedge clk) disable iff (!rst)
        (state_q == GNT_DATA) |-> data_req);
    a_pref_held: assert property (@(posedge clk) disable iff (!rst)
        (state_q == GNT_PREF) |-> bus.pref_read);

endmodule
